// File: rtl/oled_rx_pkg.sv
// oled_rx_pkg: shared definitions for the OLED serial receiver.
//   - parser_state_t : command parser states (fixed encodings)
//   - CMD_SET_COL / CMD_SET_PAGE : addressing opcodes the parser decodes
//   - COL_W / PAGE_W : address field widths for the default 128x64 panel
package oled_rx_pkg;

    localparam int NUM_COLS_DEF  = 128;
    localparam int NUM_PAGES_DEF = 8;
    localparam int COL_W         = $clog2(NUM_COLS_DEF);
    localparam int PAGE_W        = $clog2(NUM_PAGES_DEF);

    localparam logic [7:0] CMD_SET_COL  = 8'h21;
    localparam logic [7:0] CMD_SET_PAGE = 8'h22;

    // Fixed encodings so state values stay stable across tool versions.
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_COL_START  = 3'd1;
    localparam logic [2:0] ST_COL_END    = 3'd2;
    localparam logic [2:0] ST_PAGE_START = 3'd3;
    localparam logic [2:0] ST_PAGE_END   = 3'd4;

    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        COL_START  = ST_COL_START,
        COL_END    = ST_COL_END,
        PAGE_START = ST_PAGE_START,
        PAGE_END   = ST_PAGE_END
    } parser_state_t;

endpackage

// File: rtl/oled_spi_receiver_if.sv
// oled_spi_receiver_if: the four-wire OLED serial bus.
//   SCLK  serial clock        SDIN  serial data (MSB first)
//   DnC   1 = data, 0 = cmd   nCS   active-low chip select
// master drives the bus (core / testbench), slave receives it.
interface oled_spi_receiver_if;
    logic SCLK;
    logic SDIN;
    logic DnC;
    logic nCS;

    modport master (output SCLK, SDIN, DnC, nCS);
    modport slave  (input  SCLK, SDIN, DnC, nCS);
endinterface

// File: rtl/oled_spi_receiver_deser.sv
// spi_byte_deserialiser: synchronises the serial pins into HCLK, detects
// SCLK rising edges and assembles MSB-first bytes.
//   HCLK, HRESET          clock / asynchronous active-high reset
//   SCLK, SDIN, DnC, nCS  raw serial pins
//   ByteValid             one-cycle pulse when the 8th bit lands
//   ByteData              completed byte, held until the next ByteValid
//   ByteIsData            DnC sampled with the 8th bit
//   FramingError          one-cycle pulse when nCS rises on a partial byte
module spi_byte_deserialiser #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       SCLK,
    input  logic       SDIN,
    input  logic       DnC,
    input  logic       nCS,
    output logic       ByteValid,
    output logic [7:0] ByteData,
    output logic       ByteIsData,
    output logic       FramingError
);

    logic [SYNC_STAGES-1:0] sclkSync;
    logic [SYNC_STAGES-1:0] sdinSync;
    logic [SYNC_STAGES-1:0] dncSync;
    logic [SYNC_STAGES-1:0] ncsSync;

    // Stage 0 samples the pins; later stages shift the previous stage.
    // nCS resets high so the bus starts out deselected.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : gSync
            always_ff @(posedge HCLK or posedge HRESET) begin
                if (HRESET) begin
                    sclkSync[gi] <= 1'b0;
                    sdinSync[gi] <= 1'b0;
                    dncSync[gi]  <= 1'b0;
                    ncsSync[gi]  <= 1'b1;
                end else if (gi == 0) begin
                    sclkSync[gi] <= SCLK;
                    sdinSync[gi] <= SDIN;
                    dncSync[gi]  <= DnC;
                    ncsSync[gi]  <= nCS;
                end else begin
                    sclkSync[gi] <= sclkSync[(gi == 0) ? 0 : gi-1];
                    sdinSync[gi] <= sdinSync[(gi == 0) ? 0 : gi-1];
                    dncSync[gi]  <= dncSync[(gi == 0) ? 0 : gi-1];
                    ncsSync[gi]  <= ncsSync[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    logic sclkS, sdinS, dncS, ncsS;
    assign sclkS = sclkSync[SYNC_STAGES-1];
    assign sdinS = sdinSync[SYNC_STAGES-1];
    assign dncS  = dncSync[SYNC_STAGES-1];
    assign ncsS  = ncsSync[SYNC_STAGES-1];

    logic       sclkPrev;
    logic       ncsPrev;
    logic [2:0] bitCount;
    logic [7:0] shiftReg;

    logic       sclkRise, ncsRise, shiftEn, lastBit;
    logic [7:0] shiftNext;

    assign sclkRise  = sclkS & ~sclkPrev;
    assign ncsRise   = ncsS & ~ncsPrev;
    // An edge is still accepted in the cycle nCS rises, so a byte whose
    // final edge coincides with deselect completes normally.
    assign shiftEn   = sclkRise & (~ncsS | ~ncsPrev);
    assign lastBit   = shiftEn & (bitCount == 3'd7);
    assign shiftNext = {shiftReg[6:0], sdinS};

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sclkPrev     <= 1'b0;
            ncsPrev      <= 1'b1;
            bitCount     <= 3'd0;
            shiftReg     <= 8'h00;
            ByteValid    <= 1'b0;
            ByteData     <= 8'h00;
            ByteIsData   <= 1'b0;
            FramingError <= 1'b0;
        end else begin
            sclkPrev     <= sclkS;
            ncsPrev      <= ncsS;
            ByteValid    <= 1'b0;
            FramingError <= 1'b0;
            if (ncsRise && !lastBit && (bitCount != 3'd0 || shiftEn)) begin
                // Deselect on a partial byte: drop it and restart alignment.
                FramingError <= 1'b1;
                bitCount     <= 3'd0;
            end else if (shiftEn) begin
                shiftReg <= shiftNext;
                bitCount <= bitCount + 3'd1;
                if (lastBit) begin
                    ByteValid  <= 1'b1;
                    ByteData   <= shiftNext;
                    ByteIsData <= dncS;
                end
            end
        end
    end

endmodule

// File: rtl/oled_spi_receiver.sv
// oled_spi_receiver: SSD1306-style serial receiver producing framebuffer
// writes for a NUM_COLS x (NUM_PAGES*8) display model.
//   HCLK, HRESET   clock / asynchronous active-high reset
//   spiBus         serial bus (SCLK, SDIN, DnC, nCS), slave side
//   ByteValid, ByteData, ByteIsData, FramingError   raw byte stream
//   FbWrite, FbAddr {page, col}, FbData             framebuffer strobe
// Commands 0x21/0x22 set the column/page window; data bytes are written
// with horizontal auto-increment inside that window.
module oled_spi_receiver
    import oled_rx_pkg::*;
#(
    parameter int NUM_COLS    = NUM_COLS_DEF,
    parameter int NUM_PAGES   = NUM_PAGES_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                       HCLK,
    input  logic                                       HRESET,
    oled_spi_receiver_if.slave                         spiBus,
    output logic                                       ByteValid,
    output logic [7:0]                                 ByteData,
    output logic                                       ByteIsData,
    output logic                                       FbWrite,
    output logic [$clog2(NUM_PAGES)+$clog2(NUM_COLS)-1:0] FbAddr,
    output logic [7:0]                                 FbData,
    output logic                                       FramingError
);

    localparam int ColW  = $clog2(NUM_COLS);
    localparam int PageW = $clog2(NUM_PAGES);

    spi_byte_deserialiser #(
        .SYNC_STAGES (SYNC_STAGES)
    ) deser (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .SCLK         (spiBus.SCLK),
        .SDIN         (spiBus.SDIN),
        .DnC          (spiBus.DnC),
        .nCS          (spiBus.nCS),
        .ByteValid    (ByteValid),
        .ByteData     (ByteData),
        .ByteIsData   (ByteIsData),
        .FramingError (FramingError)
    );

    parser_state_t    stateReg;
    logic [ColW-1:0]  colStart, colEnd, colPtr;
    logic [PageW-1:0] pageStart, pageEnd, pagePtr;

    logic [ColW-1:0]  byteCol;
    logic [PageW-1:0] bytePage;
    logic             colWrap, pageWrap;

    assign byteCol  = ByteData[ColW-1:0];
    assign bytePage = ByteData[PageW-1:0];
    // Wrapping at the physical edge as well as the window end keeps
    // start > end windows in range.
    assign colWrap  = (colPtr == colEnd) || (colPtr == ColW'(NUM_COLS-1));
    assign pageWrap = (pagePtr == pageEnd) || (pagePtr == PageW'(NUM_PAGES-1));

    // Write happens in the ByteValid cycle using the pre-advance pointer.
    assign FbWrite = ByteValid & ByteIsData;
    assign FbAddr  = {pagePtr, colPtr};
    assign FbData  = ByteData;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            stateReg  <= IDLE;
            colStart  <= '0;
            colEnd    <= ColW'(NUM_COLS-1);
            colPtr    <= '0;
            pageStart <= '0;
            pageEnd   <= PageW'(NUM_PAGES-1);
            pagePtr   <= '0;
        end else if (ByteValid) begin
            if (ByteIsData) begin
                // Data aborts any half-finished addressing command; values
                // already stored are kept but the pointer is not reloaded.
                stateReg <= IDLE;
                if (colWrap) begin
                    colPtr  <= colStart;
                    pagePtr <= pageWrap ? pageStart : pagePtr + PageW'(1);
                end else begin
                    colPtr <= colPtr + ColW'(1);
                end
            end else begin
                case (stateReg)
                    IDLE: begin
                        if (ByteData == CMD_SET_COL)
                            stateReg <= COL_START;
                        else if (ByteData == CMD_SET_PAGE)
                            stateReg <= PAGE_START;
                    end
                    COL_START: begin
                        colStart <= byteCol;
                        stateReg <= COL_END;
                    end
                    COL_END: begin
                        colEnd   <= byteCol;
                        colPtr   <= colStart;
                        stateReg <= IDLE;
                    end
                    PAGE_START: begin
                        pageStart <= bytePage;
                        stateReg  <= PAGE_END;
                    end
                    PAGE_END: begin
                        pageEnd  <= bytePage;
                        pagePtr  <= pageStart;
                        stateReg <= IDLE;
                    end
                    default: stateReg <= IDLE;
                endcase
            end
        end
    end

endmodule
